instr_imm_encoder: RTL and testbench

Inverse of the decode-stage immediate sign-extender: accepts a 32-bit signed immediate and an instruction template, range-checks the immediate for the selected format (I/S/B/J), scatters its bits into the RISC-V immediate field positions and emits the finished instruction word through a registered valid/ready output stage. It sits in the test/program-loader path ahead of instruction memory. Any legal word it emits, decoded with the same ImmSrc, must return the original immediate.

---
 rtl/instr_imm_pkg.sv | 50 +++++
 rtl/imm_scatter.sv | 68 ++++++
 rtl/instr_imm_encoder.sv | 105 ++++++++++
 tb/tb_instr_imm_encoder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_imm_pkg.sv
// -----------------------------------------------------------------------------
// instr_imm_pkg
// Shared types and constants for the immediate encoder:
//   imm_src_e    - immediate format selector (same encoding as decode ImmSrc)
//   out_state_e  - output register occupancy
//   *_MIN/*_MAX  - legal signed immediate range per format
//   *_MASK       - instruction bit positions owned by the immediate per format
// -----------------------------------------------------------------------------
package instr_imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    localparam logic signed [31:0] I_MIN = -32'sd2048;
    localparam logic signed [31:0] I_MAX =  32'sd2047;
    localparam logic signed [31:0] S_MIN = -32'sd2048;
    localparam logic signed [31:0] S_MAX =  32'sd2047;
    localparam logic signed [31:0] B_MIN = -32'sd4096;
    localparam logic signed [31:0] B_MAX =  32'sd4094;
    localparam logic signed [31:0] J_MIN = -32'sd1048576;
    localparam logic signed [31:0] J_MAX =  32'sd1048574;

    localparam logic [31:0] I_MASK = 32'hFFF0_0000;
    localparam logic [31:0] S_MASK = 32'hFE00_0F80;
    localparam logic [31:0] B_MASK = 32'hFE00_0F80;
    localparam logic [31:0] J_MASK = 32'hFFFF_F000;

    function automatic logic [31:0] imm_mask(input imm_src_e src);
        logic [31:0] m;
        m = I_MASK;
        case (src)
            IMM_I: m = I_MASK;
            IMM_S: m = S_MASK;
            IMM_B: m = B_MASK;
            IMM_J: m = J_MASK;
            default: m = I_MASK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// -----------------------------------------------------------------------------
// imm_scatter
// Combinational core of the encoder: range/alignment check of a signed
// immediate for the selected format and placement of its bits into the
// RISC-V immediate fields of an instruction template.
// Ports:
//   ImmSrc     in  2   format select (I/S/B/J)
//   instr_base in  32  template; bits under the format's immediate mask ignored
//   imm        in  32  signed immediate (byte offset for B/J)
//   instr      out 32  template with immediate fields filled (zero if err)
//   err        out 1   immediate out of range or misaligned
// -----------------------------------------------------------------------------
module imm_scatter
    import instr_imm_pkg::*;
(
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] instr_base,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    imm_src_e           w_src;
    logic signed [31:0] w_simm;
    logic [31:0]        w_field;
    logic [31:0]        w_mask;
    logic               w_in_range;
    logic               w_aligned;

    assign w_src  = imm_src_e'(ImmSrc);
    assign w_simm = imm;
    assign w_mask = imm_mask(w_src);

    always_comb begin
        w_field    = '0;
        w_in_range = 1'b0;
        w_aligned  = 1'b1;
        case (w_src)
            IMM_I: begin
                w_field    = {imm[11:0], 20'b0};
                w_in_range = (w_simm >= I_MIN) && (w_simm <= I_MAX);
            end
            IMM_S: begin
                w_field    = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                w_in_range = (w_simm >= S_MIN) && (w_simm <= S_MAX);
            end
            IMM_B: begin
                w_field    = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                w_in_range = (w_simm >= B_MIN) && (w_simm <= B_MAX);
                w_aligned  = ~imm[0];
            end
            IMM_J: begin
                w_field    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                w_in_range = (w_simm >= J_MIN) && (w_simm <= J_MAX);
                w_aligned  = ~imm[0];
            end
            default: begin
                w_field    = '0;
                w_in_range = 1'b0;
            end
        endcase
    end

    // Illegal immediates leave the field zeroed but keep the template bits.
    assign err   = ~(w_in_range & w_aligned);
    assign instr = (instr_base & ~w_mask) | (err ? '0 : w_field);

endmodule

// File: rtl/instr_imm_encoder.sv
// -----------------------------------------------------------------------------
// instr_imm_encoder
// Encodes a signed immediate into an instruction template and emits the word
// through a single registered valid/ready stage, with saturating counters of
// good and erroneous words delivered downstream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready = ~out_valid | out_ready)
//   ImmSrc, instr_base,   request payload, sampled only on accept
//   imm
//   out_valid / out_ready output handshake
//   instr, err            registered encoded word and its error flag
//   enc_count, err_count  saturating counts of delivered good / bad words
// -----------------------------------------------------------------------------
module instr_imm_encoder
    import instr_imm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ImmSrc,
    input  logic [31:0]      instr_base,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic [31:0]      r_instr;
    logic             r_err;
    logic [CNT_W-1:0] r_enc_count;
    logic [CNT_W-1:0] r_err_count;
    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_accept;
    logic             w_handshake;

    imm_scatter u_scatter (
        .ImmSrc     (ImmSrc),
        .instr_base (instr_base),
        .imm        (imm),
        .instr      (w_instr),
        .err        (w_err)
    );

    assign out_valid   = (r_state == ST_FULL);
    assign in_ready    = ~out_valid | out_ready;
    assign w_accept    = in_valid & in_ready;
    assign w_handshake = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Accept is only possible when the register is empty or draining this
    // cycle, so loading on accept never overwrites an undelivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_instr <= w_instr;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_handshake) begin
            if (!r_err && r_enc_count != CNT_MAX) r_enc_count <= r_enc_count + CNT_W'(1);
            if (r_err && r_err_count != CNT_MAX)  r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign instr     = r_instr;
    assign err       = r_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_imm_encoder
// Scoreboard bench: the driver pushes the expected word for every accepted
// request; a monitor pops and compares on each output handshake, checks
// counters each cycle and decodes good words back to their immediate.
// A second instance with CNT_W=4 shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_instr_imm_encoder;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  src;
        logic [31:0] imm;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ImmSrc;
    logic [31:0] instr_base;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] instr4;
    logic        err4;
    logic [3:0]  enc_count4;
    logic [3:0]  err_count4;

    exp_t sb[$];
    int   hs_cycles[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_enc  = 0;
    int   exp_err  = 0;
    bit   rnd_ready = 0;

    instr_imm_encoder #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ImmSrc(ImmSrc), .instr_base(instr_base), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .err(err),
        .enc_count(enc_count), .err_count(err_count)
    );

    instr_imm_encoder #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .ImmSrc(ImmSrc), .instr_base(instr_base), .imm(imm),
        .out_valid(out_valid4), .out_ready(out_ready), .instr(instr4), .err(err4),
        .enc_count(enc_count4), .err_count(err_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Source immediate bit for instruction bit p, or -1 if p belongs to the template.
    function automatic int field_src(input logic [1:0] s, input int p);
        case (s)
            2'd0: return (p >= 20) ? p - 20 : -1;
            2'd1: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
                return -1;
            end
            2'd2: begin
                if (p == 31) return 12;
                if (p >= 25) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                if (p == 7) return 11;
                return -1;
            end
            default: begin
                if (p == 31) return 20;
                if (p >= 21) return p - 20;
                if (p == 20) return 11;
                if (p >= 12) return p;
                return -1;
            end
        endcase
    endfunction

    function automatic void model(input logic [1:0] s, input logic [31:0] base, input logic [31:0] im,
                                  output logic [31:0] ins, output logic e);
        int v;
        int lo;
        int hi;
        bit need_even;
        v = int'(im);
        case (s)
            2'd0, 2'd1: begin lo = -2048;    hi = 2047;    need_even = 0; end
            2'd2:       begin lo = -4096;    hi = 4094;    need_even = 1; end
            default:    begin lo = -1048576; hi = 1048574; need_even = 1; end
        endcase
        e = (v < lo) || (v > hi) || (need_even && im[0]);
        for (int p = 0; p < 32; p++) begin
            int src;
            src = field_src(s, p);
            if (src < 0) ins[p] = base[p];
            else         ins[p] = e ? 1'b0 : im[src];
        end
    endfunction

    // Decode-stage sign extender, used to close the round trip.
    function automatic logic [31:0] dec_imm(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] rand_imm(input logic [1:0] s, input bit legal);
        int v;
        if (!legal) return $urandom;
        case (s)
            2'd0, 2'd1: v = int'($urandom_range(0, 4095)) - 2048;
            2'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            default:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        endcase
        return 32'(v);
    endfunction

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("enc_count", 32'(enc_count), 32'(sat(exp_enc, 65535)));
            chk("err_count", 32'(err_count), 32'(sat(exp_err, 65535)));
            chk("enc_count_w4", 32'(enc_count4), 32'(sat(exp_enc, 15)));
            chk("err_count_w4", 32'(err_count4), 32'(sat(exp_err, 15)));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: got instr %h with empty scoreboard expected no output", instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("instr", instr, e.instr);
                    chk("err", 32'(err), 32'(e.err));
                    if (!e.err) chk("round_trip", dec_imm(instr, e.src), e.imm);
                    if (e.err) exp_err++;
                    else       exp_enc++;
                end
                hs_cycles.push_back(cyc);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] b, input logic [31:0] im,
                        input bit dir, input logic [31:0] dins, input logic derr);
        exp_t        e;
        logic [31:0] mi;
        logic        me;
        int          t;
        bit          r;
        in_valid   = 1'b1;
        ImmSrc     = s;
        instr_base = b;
        imm        = im;
        model(s, b, im, mi, me);
        e.instr = dir ? dins : mi;
        e.err   = dir ? derr : me;
        e.src   = s;
        e.imm   = im;
        t = 0;
        r = 0;
        while (!r && t < 200) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            t++;
        end
        if (r) sb.push_back(e);
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected accept", t);
        end
        #1;
        in_valid   = 1'b0;
        ImmSrc     = 2'($urandom);
        instr_base = $urandom;
        imm        = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d words pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_rand(input bit legal);
        logic [1:0] s;
        s = 2'($urandom);
        send(s, $urandom, rand_imm(s, legal), 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] held;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ImmSrc     = '0;
        instr_base = '0;
        imm        = '0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_enc", 32'(enc_count), 32'd0);
        chk("reset_errc", 32'(err_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sync();

        // Directed vectors
        send(2'd0, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0013, 1'b0);
        send(2'd1, 32'h0000_2023, 32'd2047,      1'b1, 32'h7E00_2FA3, 1'b0);
        send(2'd2, 32'h0000_0063, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3, 1'b0);
        send(2'd3, 32'h0000_006F, 32'd2048,      1'b1, 32'h0010_006F, 1'b0);
        send(2'd2, 32'h0000_0063, 32'd3,         1'b1, 32'h0000_0063, 1'b1);
        send(2'd0, 32'h0000_0013, 32'd2048,      1'b1, 32'h0000_0013, 1'b1);
        drain();
        chk("directed_enc_count", 32'(enc_count), 32'd4);
        chk("directed_err_count", 32'(err_count), 32'd2);

        // Boundary immediates around each legal range
        send(2'd0, $urandom, 32'hFFFF_F800, 1'b0, '0, 1'b0);
        send(2'd0, $urandom, 32'hFFFF_F7FF, 1'b0, '0, 1'b0);
        send(2'd1, $urandom, 32'd2047,      1'b0, '0, 1'b0);
        send(2'd2, $urandom, 32'd4094,      1'b0, '0, 1'b0);
        send(2'd2, $urandom, 32'd4096,      1'b0, '0, 1'b0);
        send(2'd2, $urandom, 32'hFFFF_F000, 1'b0, '0, 1'b0);
        send(2'd3, $urandom, 32'd1048574,   1'b0, '0, 1'b0);
        send(2'd3, $urandom, 32'd1048576,   1'b0, '0, 1'b0);
        send(2'd3, $urandom, 32'hFFF0_0000, 1'b0, '0, 1'b0);
        send(2'd3, $urandom, 32'hFFF0_0001, 1'b0, '0, 1'b0);
        drain();

        // Back-to-back throughput
        hs_cycles.delete();
        for (int n = 0; n < 8; n++) send_rand(1'b1);
        drain();
        chk("b2b_count", 32'(hs_cycles.size()), 32'd8);
        if (hs_cycles.size() == 8) chk("b2b_consecutive", 32'(hs_cycles[7] - hs_cycles[0]), 32'd7);

        // Stall: word held stable, in_ready low, nothing lost after release
        out_ready = 1'b0;
        send_rand(1'b1);
        held       = sb[0].instr;
        in_valid   = 1'b1;
        ImmSrc     = 2'd0;
        instr_base = 32'h0000_0093;
        imm        = 32'd5;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_instr", instr, held);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            if (n == 2) begin
                instr_base = $urandom;
                imm        = $urandom;
            end
        end
        sync();
        out_ready = 1'b1;
        send(2'd0, 32'h0000_0093, 32'd5, 1'b1, 32'h0050_0093, 1'b0);
        drain();

        // Random traffic with random backpressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 1000; n++) send_rand($urandom_range(0, 9) != 0);
        rnd_ready = 1'b0;
        sync();
        out_ready = 1'b1;
        drain();

        // Reset while a word is stalled in the output register
        out_ready = 1'b0;
        send_rand(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_enc", 32'(enc_count), 32'd0);
        chk("midrst_errc", 32'(err_count), 32'd0);
        chk("midrst_enc_w4", 32'(enc_count4), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        exp_enc = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        chk("postrst_out_valid", 32'(out_valid), 32'd0);

        // Saturation of the narrow counter
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) send_rand(1'b1);
        drain();
        chk("sat_enc_w16", 32'(enc_count), 32'd20);
        chk("sat_enc_w4", 32'(enc_count4), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

endmodule
